// File: rtl/load_store_unit.sv
// Memory stage of the RV32 core: turns one load or store into a single word-wide
// valid/ready data-memory transaction and returns extended load data or an error code.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wbe,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        done_valid,
    output logic [31:0] done_data,
    output logic [1:0]  done_err
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ERR_W = 2;

    localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
    localparam logic [ERR_W-1:0] ERR_MISALGN = 2'b01;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'b11;

    // One-hot so every state-decoded output is a single flop bit.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_REQ  = 4'b0010,
        S_WAIT = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        offs_q;
    logic [2:0]        funct3_q;

    logic              accept_c;
    logic              wait_timeout_c;
    logic [ERR_W-1:0]  req_err_c;
    logic [3:0]        st_wbe_c;
    logic [XLEN-1:0]   st_wdata_c;
    logic [7:0]        ld_byte_c;
    logic [15:0]       ld_half_c;
    logic [XLEN-1:0]   ld_data_c;

    assign accept_c       = (state_q == S_IDLE) && req_valid;
    assign wait_timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Request legality: illegal funct3 beats misalignment.
    always_comb begin
        req_err_c = ERR_OK;
        case (req_funct3)
            3'b000, 3'b100: req_err_c = ERR_OK;
            3'b001, 3'b101: req_err_c = req_addr[0] ? ERR_MISALGN : ERR_OK;
            3'b010:         req_err_c = (req_addr[1:0] != 2'b00) ? ERR_MISALGN : ERR_OK;
            default:        req_err_c = ERR_ILLEGAL;
        endcase
    end

    // Store lane replication and byte enables.
    always_comb begin
        st_wdata_c = req_wdata;
        st_wbe_c   = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata_c = {4{req_wdata[7:0]}};
                st_wbe_c   = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata_c = {2{req_wdata[15:0]}};
                st_wbe_c   = 4'b0011 << req_addr[1:0];
            end
            default: begin
                st_wdata_c = req_wdata;
                st_wbe_c   = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension.
    always_comb begin
        ld_byte_c = mem_rdata[{offs_q, 3'b000} +: 8];
        ld_half_c = mem_rdata[{offs_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            3'b100:  ld_data_c = {24'd0, ld_byte_c};
            3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
            3'b101:  ld_data_c = {16'd0, ld_half_c};
            default: ld_data_c = mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = (req_err_c != ERR_OK) ? S_DONE : S_REQ;
            S_REQ:  if (mem_req_ready) state_d = mem_we ? S_DONE : S_WAIT;
            S_WAIT: if (mem_rsp_valid || wait_timeout_c) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state flops.
    always_comb begin
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        done_valid    = 1'b0;
        case (state_q)
            S_IDLE:  req_ready     = 1'b1;
            S_REQ:   mem_req_valid = 1'b1;
            S_DONE:  done_valid    = 1'b1;
            default: ;
        endcase
    end

    // Request capture, response timeout counter and completion payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            offs_q    <= '0;
            funct3_q  <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wbe   <= '0;
            mem_wdata <= '0;
            done_data <= '0;
            done_err  <= ERR_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c && (req_err_c == ERR_OK)) begin
                        offs_q    <= req_addr[1:0];
                        funct3_q  <= req_funct3;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_we    <= req_we;
                        mem_wbe   <= req_we ? st_wbe_c : 4'b0000;
                        mem_wdata <= req_we ? st_wdata_c : '0;
                    end
                    if (accept_c) begin
                        done_data <= '0;
                        done_err  <= req_err_c;
                    end
                end
                S_REQ: begin
                    cnt_q <= '0;
                    if (mem_req_ready) begin
                        done_data <= '0;
                        done_err  <= ERR_OK;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        done_data <= ld_data_c;
                        done_err  <= ERR_OK;
                    end else if (wait_timeout_c) begin
                        done_data <= '0;
                        done_err  <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_data <= '0;
                    done_err  <= ERR_OK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, errors, stalls, timeout and async reset.
module tb_load_store_unit;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 5;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wbe;
    logic        mem_rsp_valid;
    logic        done_valid;
    logic [31:0] done_data;
    logic [1:0]  done_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wbe(mem_wbe), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .done_valid(done_valid), .done_data(done_data), .done_err(done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request; returns just after the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rdata = '0;
        tick(); tick();
        n_total++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end else n_pass++;
        n_total++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_valid got=%b exp=0", mem_req_valid); end else n_pass++;
        n_total++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done_valid got=%b exp=0", done_valid); end else n_pass++;
        n_total++; if ({mem_addr, mem_wdata, mem_wbe, mem_we} !== 69'd0) begin n_fail++; $display("FAIL rst_mem_bus got=%h/%h/%b/%b exp=0", mem_addr, mem_wdata, mem_wbe, mem_we); end else n_pass++;
        n_total++; if ({done_data, done_err} !== 34'd0) begin n_fail++; $display("FAIL rst_done_payload got=%h/%b exp=0", done_data, done_err); end else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store();
        logic [2:0]  f3 [3]  = '{3'b010, 3'b000, 3'b001};
        logic [31:0] ad [3]  = '{32'h100, 32'h103, 32'h102};
        logic [31:0] dd [3]  = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234};
        logic [31:0] ew [3]  = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'h12341234};
        logic [3:0]  eb [3]  = '{4'b1111, 4'b1000, 4'b1100};
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, f3[i], ad[i], dd[i]);
            n_total++; if (mem_req_valid !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL st%0d_req got valid=%b ready=%b exp 1/0", i, mem_req_valid, req_ready); end else n_pass++;
            n_total++; if (mem_addr !== 32'h100 || mem_we !== 1'b1) begin n_fail++; $display("FAIL st%0d_addr got=%h we=%b exp=00000100 we=1", i, mem_addr, mem_we); end else n_pass++;
            n_total++; if (mem_wdata !== ew[i] || mem_wbe !== eb[i]) begin n_fail++; $display("FAIL st%0d_lanes got=%h/%b exp=%h/%b", i, mem_wdata, mem_wbe, ew[i], eb[i]); end else n_pass++;
            n_total++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL st%0d_early_done got=%b exp=0", i, done_valid); end else n_pass++;
            tick();
            n_total++; if (done_valid !== 1'b1 || done_err !== 2'b00 || done_data !== 32'd0) begin n_fail++; $display("FAIL st%0d_done got=%b/%b/%h exp=1/00/0", i, done_valid, done_err, done_data); end else n_pass++;
            n_total++; if (req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL st%0d_done_hs got ready=%b mrv=%b exp 0/0", i, req_ready, mem_req_valid); end else n_pass++;
            tick();
            n_total++; if (done_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL st%0d_idle got done=%b ready=%b exp 0/1", i, done_valid, req_ready); end else n_pass++;
        end
    endtask

    task automatic test_load();
        logic [2:0]  f3 [6] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b010, 3'b100};
        logic [31:0] ad [6] = '{32'h101, 32'h103, 32'h102, 32'h102, 32'h100, 32'h103};
        logic [31:0] ed [6] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080F1, 32'hFFFF80F1, 32'h80F17F01, 32'h00000080};
        mem_req_ready = 1'b1;
        mem_rdata     = 32'h80F17F01;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, f3[i], ad[i], 32'hFFFFFFFF);
            n_total++; if (mem_req_valid !== 1'b1 || mem_we !== 1'b0 || mem_wbe !== 4'b0000 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL ld%0d_req got v=%b we=%b wbe=%b a=%h", i, mem_req_valid, mem_we, mem_wbe, mem_addr); end else n_pass++;
            tick();
            n_total++; if (mem_req_valid !== 1'b0 || done_valid !== 1'b0) begin n_fail++; $display("FAIL ld%0d_wait got mrv=%b done=%b exp 0/0", i, mem_req_valid, done_valid); end else n_pass++;
            mem_rsp_valid = 1'b1;
            tick();
            mem_rsp_valid = 1'b0;
            n_total++; if (done_valid !== 1'b1 || done_err !== 2'b00 || done_data !== ed[i]) begin n_fail++; $display("FAIL ld%0d_data got=%b/%b/%h exp=1/00/%h", i, done_valid, done_err, done_data, ed[i]); end else n_pass++;
            tick();
        end
    endtask

    task automatic test_errors();
        logic [2:0]  f3 [4] = '{3'b010, 3'b001, 3'b011, 3'b110};
        logic [31:0] ad [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
        logic [1:0]  ee [4] = '{2'b01, 2'b01, 2'b11, 2'b11};
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(i[0], f3[i], ad[i], 32'h0);
            n_total++; if (done_valid !== 1'b1 || done_err !== ee[i] || done_data !== 32'd0) begin n_fail++; $display("FAIL err%0d got=%b/%b/%h exp=1/%b/0", i, done_valid, done_err, done_data, ee[i]); end else n_pass++;
            n_total++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL err%0d_mem_touched got=%b exp=0", i, mem_req_valid); end else n_pass++;
            tick();
            n_total++; if (mem_req_valid !== 1'b0 || done_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL err%0d_after got mrv=%b done=%b ready=%b", i, mem_req_valid, done_valid, req_ready); end else n_pass++;
        end
    endtask

    task automatic test_stall();
        mem_req_ready = 1'b0;
        issue(1'b1, 3'b010, 32'h204, 32'h11223344);
        for (int i = 0; i < 5; i++) begin
            n_total++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h204 || mem_wdata !== 32'h11223344 || mem_wbe !== 4'b1111 || mem_we !== 1'b1) begin n_fail++; $display("FAIL stall%0d got v=%b a=%h d=%h be=%b", i, mem_req_valid, mem_addr, mem_wdata, mem_wbe); end else n_pass++;
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        n_total++; if (done_valid !== 1'b1 || done_err !== 2'b00) begin n_fail++; $display("FAIL stall_done got=%b/%b exp=1/00", done_valid, done_err); end else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            mem_req_ready = 1'b1;
            mem_rdata     = 32'hCAFEF00D;
            issue(1'b0, 3'b010, 32'h300, 32'h0);
            tick();
            for (int i = 0; i < int'(TIMEOUT); i++) begin
                n_total++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL to%0d_early cycle=%0d got=%b exp=0", pass, i, done_valid); end else n_pass++;
                if (pass == 1 && i == int'(TIMEOUT) - 1) mem_rsp_valid = 1'b1;
                tick();
                mem_rsp_valid = 1'b0;
            end
            if (pass == 0) begin
                n_total++; if (done_valid !== 1'b1 || done_err !== 2'b10 || done_data !== 32'd0) begin n_fail++; $display("FAIL timeout got=%b/%b/%h exp=1/10/0", done_valid, done_err, done_data); end else n_pass++;
            end else begin
                n_total++; if (done_valid !== 1'b1 || done_err !== 2'b00 || done_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL late_rsp got=%b/%b/%h exp=1/00/cafef00d", done_valid, done_err, done_data); end else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_stray_rsp();
        mem_rsp_valid = 1'b1;
        tick(); tick();
        mem_rsp_valid = 1'b0;
        n_total++; if (done_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL stray_rsp got done=%b ready=%b exp 0/1", done_valid, req_ready); end else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int pass = 0; pass < 2; pass++) begin
            mem_req_ready = (pass == 1);
            issue(pass == 0, 3'b010, 32'h400, 32'h55AA55AA);
            if (pass == 1) begin
                mem_req_ready = 1'b0;
                tick();
            end
            #2 rst_n = 1'b0;
            #1;
            n_total++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL arst%0d got mrv=%b ready=%b exp 0/1", pass, mem_req_valid, req_ready); end else n_pass++;
            tick();
            rst_n = 1'b1;
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                n_total++; if (done_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL arst%0d_release%0d got done=%b mrv=%b exp 0/0", pass, i, done_valid, mem_req_valid); end else n_pass++;
            end
            mem_rsp_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_errors();
        test_stall();
        test_timeout();
        test_stray_rsp();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
